// File: rtl/sensor_input_conditioner.sv
// Front-end conditioner for the six irrigation field sensors: two-flop
// synchronisers, per-channel debounce, a post-reset warm-up qualifier and a
// change strobe for downstream logic.
module sensor_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic clock,
    input  logic reset,
    input  logic sample_enable,
    input  logic raw_low_water_level,
    input  logic raw_mid_water_level,
    input  logic raw_high_water_level,
    input  logic raw_earth_humidity,
    input  logic raw_air_humidity,
    input  logic raw_low_temperature,
    output logic low_water_level,
    output logic mid_water_level,
    output logic high_water_level,
    output logic earth_humidity,
    output logic air_humidity,
    output logic low_temperature,
    output logic sensors_valid,
    output logic change_strobe
);

    localparam int NUM_CH = 6;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WARM_DONE  = CNT_W'(DEBOUNCE_CYCLES + 2);

    logic [NUM_CH-1:0] raw_bus;
    logic [NUM_CH-1:0] sync1_reg;
    logic [NUM_CH-1:0] sync2_reg;
    logic [NUM_CH-1:0] stable_bus;
    logic [NUM_CH-1:0] update_bus;
    logic [CNT_W-1:0]  warm_reg;
    logic              strobe_reg;

    // Bit order: 0 low, 1 mid, 2 high water, 3 earth, 4 air, 5 low temperature.
    assign raw_bus = {raw_low_temperature, raw_air_humidity, raw_earth_humidity,
                      raw_high_water_level, raw_mid_water_level, raw_low_water_level};

    // Two-stage synchroniser; runs every clock regardless of sample_enable.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= raw_bus;
            sync2_reg <= sync1_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
            logic [CNT_W-1:0] count_reg;
            logic             stable_reg;
            logic             differs;

            assign differs        = sync2_reg[gi] != stable_reg;
            assign update_bus[gi] = differs && sample_enable && (count_reg == LAST_COUNT);
            assign stable_bus[gi] = stable_reg;

            // Debounce: any return to the stable level discards the partial count.
            always_ff @(posedge clock) begin
                if (reset) begin
                    count_reg  <= '0;
                    stable_reg <= 1'b0;
                end else if (!differs) begin
                    count_reg <= '0;
                end else if (sample_enable) begin
                    if (count_reg == LAST_COUNT) begin
                        stable_reg <= sync2_reg[gi];
                        count_reg  <= '0;
                    end else begin
                        count_reg <= count_reg + 1'b1;
                    end
                end
            end
        end
    endgenerate

    // Warm-up counter saturates once the debounce pipeline has fully flushed.
    always_ff @(posedge clock) begin
        if (reset) begin
            warm_reg <= '0;
        end else if (sample_enable && (warm_reg != WARM_DONE)) begin
            warm_reg <= warm_reg + 1'b1;
        end
    end

    assign sensors_valid = (warm_reg == WARM_DONE);

    // Strobe uses the pre-edge valid, so it stays low on the cycle valid rises.
    always_ff @(posedge clock) begin
        if (reset) begin
            strobe_reg <= 1'b0;
        end else begin
            strobe_reg <= (|update_bus) && sensors_valid;
        end
    end

    assign change_strobe    = strobe_reg;
    assign low_water_level  = stable_bus[0];
    assign mid_water_level  = stable_bus[1];
    assign high_water_level = stable_bus[2];
    assign earth_humidity   = stable_bus[3];
    assign air_humidity     = stable_bus[4];
    assign low_temperature  = stable_bus[5];

endmodule
